// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, datapath
// control encodings, FSM state type.
package cpu_pkg;

  // Opcodes (4-bit). 10..14 are unused and decode as NOP.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_LDX  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MOVZ = 4'd5;
  localparam logic [3:0] OP_SHRY = 4'd6;
  localparam logic [3:0] OP_SHLY = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  // X/Z register controls (2-bit).
  localparam logic [1:0] CTL_HOLD  = 2'd0;
  localparam logic [1:0] CTL_LOAD  = 2'd1;
  localparam logic [1:0] CTL_CLEAR = 2'd2;

  // Y register controls (3-bit, adds the two shifts).
  localparam logic [2:0] Y_HOLD  = 3'd0;
  localparam logic [2:0] Y_LOAD  = 3'd1;
  localparam logic [2:0] Y_CLEAR = 3'd2;
  localparam logic [2:0] Y_SHR   = 3'd3;
  localparam logic [2:0] Y_SHL   = 3'd4;

  // ULA operation select.
  localparam logic ULA_ADD = 1'b0;
  localparam logic ULA_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: datapath control codes plus flow-control flags.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] ir_func,
  output logic [1:0] tx,
  output logic [2:0] ty,
  output logic [1:0] tz,
  output logic       tula,
  output logic       is_jump,
  output logic       is_jz,
  output logic       is_halt
);

  // Table lookup from opcode to controls; anything not listed is a NOP.
  always_comb begin
    tx      = CTL_HOLD;
    ty      = Y_HOLD;
    tz      = CTL_HOLD;
    tula    = ULA_ADD;
    is_jump = 1'b0;
    is_jz   = 1'b0;
    is_halt = 1'b0;
    case (ir_func)
      OP_CLR: begin
        tx = CTL_CLEAR;
        ty = Y_CLEAR;
        tz = CTL_CLEAR;
      end
      OP_LDX:  tx = CTL_LOAD;
      OP_ADD: begin
        tula = ULA_ADD;
        ty   = Y_LOAD;
      end
      OP_SUB: begin
        tula = ULA_SUB;
        ty   = Y_LOAD;
      end
      OP_MOVZ: tz      = CTL_LOAD;
      OP_SHRY: ty      = Y_SHR;
      OP_SHLY: ty      = Y_SHL;
      OP_JMP:  is_jump = 1'b1;
      OP_JZ:   is_jz   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Two-cycle-per-instruction fetch/execute sequencer for the X/Y/Z/ULA datapath.
//
// Handshake: start is a level sampled on every rising edge. It is accepted only
// when busy=0 (IDLE or HALTED); acceptance forces pc to 0 and enters FETCH.
// While busy=1 (FETCH or EXEC) start is ignored. halted=1 reports that a HALT
// retired; pc then still addresses that HALT instruction.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_zero,
  input  logic [3:0] mem_func,
  input  logic [3:0] mem_val,
  output logic [3:0] pc,
  output logic [1:0] tX,
  output logic [2:0] tY,
  output logic [1:0] tZ,
  output logic       tULA,
  output logic       busy,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] ir_func_q, ir_func_d;
  logic [3:0] ir_val_q, ir_val_d;

  logic [1:0] dec_tx;
  logic [2:0] dec_ty;
  logic [1:0] dec_tz;
  logic       dec_tula;
  logic       dec_is_jump;
  logic       dec_is_jz;
  logic       dec_is_halt;
  logic       in_exec;

  cpu_decoder u_decoder (
    .ir_func (ir_func_q),
    .tx      (dec_tx),
    .ty      (dec_ty),
    .tz      (dec_tz),
    .tula    (dec_tula),
    .is_jump (dec_is_jump),
    .is_jz   (dec_is_jz),
    .is_halt (dec_is_halt)
  );

  // State, program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= 4'd0;
      ir_func_q <= 4'd0;
      ir_val_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_func_q <= ir_func_d;
      ir_val_q  <= ir_val_d;
    end
  end

  // Next state; pc only moves when leaving EXEC or when (re)starting.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_func_d = ir_func_q;
    ir_val_d  = ir_val_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = 4'd0;
        end
      end
      ST_FETCH: begin
        ir_func_d = mem_func;
        ir_val_d  = mem_val;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
          if (dec_is_jump || (dec_is_jz && y_zero)) pc_d = ir_val_q;
          else                                      pc_d = pc_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controls are the registered-opcode decode, gated so they pulse only in EXEC.
  assign in_exec = (state_q == ST_EXEC);
  assign tX      = in_exec ? dec_tx   : CTL_HOLD;
  assign tY      = in_exec ? dec_ty   : Y_HOLD;
  assign tZ      = in_exec ? dec_tz   : CTL_HOLD;
  assign tULA    = in_exec ? dec_tula : ULA_ADD;
  assign busy    = (state_q == ST_FETCH) || in_exec;
  assign halted  = (state_q == ST_HALTED);
  assign pc      = pc_q;

endmodule
